serial_add_ctrl: RTL

//   Bit-serial add/subtract sequencer for the EX stage. It walks one full-adder

---
 rtl/serial_add_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer built around a two-half-adder full-adder cell
`timescale 1ns/1ps

module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             busy
);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              carry_q, carry_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [WIDTH-2:0]  acc_q, acc_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;

   logic              bit_a, bit_b;
   logic              ha0_s, ha0_c, ha1_c;
   logic              fa_s, fa_c;
   logic              last_bit;
   logic [WIDTH-1:0]  shifted;

   assign bit_a = a_q[idx_q];
   assign bit_b = b_q[idx_q];

   half_adder u_ha0 (
      .x (bit_a),
      .y (bit_b),
      .s (ha0_s),
      .c (ha0_c)
   );

   half_adder u_ha1 (
      .x (ha0_s),
      .y (carry_q),
      .s (fa_s),
      .c (ha1_c)
   );

   assign fa_c     = ha0_c | ha1_c;
   assign last_bit = (idx_q == IW'(WIDTH - 1));
   // New bit enters at the MSB; after WIDTH steps the LSB has walked down to bit 0.
   assign shifted  = {fa_s, acc_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               // Subtraction as A + ~B + 1: the +1 rides in on the initial carry.
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            carry_d = fa_c;
            acc_d   = shifted[WIDTH-1:1];
            if (last_bit) begin
               sum_d   = shifted;
               cout_d  = fa_c;
               ovf_d   = carry_q ^ fa_c;
               idx_d   = '0;
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + IW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;

endmodule
